// File: rtl/spi_target_pkg.sv
// Shared register map, bit positions and FSM state type for the SPI responder.
package spi_target_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DEFAULT = 2'd3;

  localparam int unsigned ST_RX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_OVR   = 2;
  localparam int unsigned ST_TX_UND   = 3;
  localparam int unsigned ST_BUSY     = 4;
  localparam int unsigned ST_IRQ      = 7;

  localparam int unsigned CT_EN     = 0;
  localparam int unsigned CT_RX_IRQ = 1;
  localparam int unsigned CT_TX_IRQ = 2;

  typedef enum logic {IDLE, SHIFT} spi_target_state_t;

endpackage

// File: rtl/spi_target_sync.sv
// Pin synchronizer: SYNC_STAGES flops, then one flop for rise/fall detection.
module spi_target_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      last_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~last_q;
  assign fall_o  = ~level_o & last_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 responder on the 6502 bus; SPI pins oversampled in the i_clk domain.
// Build option SPI_TARGET_IRQ_EN enables the interrupt output and CTRL[2:1].
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cs,
  input  logic       i_rwb,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_clk,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  output logic       o_irqb
);

  logic cs_n_unused_lvl, cs_n_rise, cs_n_fall;
  logic sclk_unused_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_unused_rise, mosi_unused_fall;

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk_i(i_clk), .rst_ni(i_rst_n), .pin_i(i_spi_cs_n),
    .level_o(cs_n_unused_lvl), .rise_o(cs_n_rise), .fall_o(cs_n_fall)
  );
  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(i_clk), .rst_ni(i_rst_n), .pin_i(i_spi_clk),
    .level_o(sclk_unused_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(i_clk), .rst_ni(i_rst_n), .pin_i(i_spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_unused_rise), .fall_o(mosi_unused_fall)
  );

  spi_target_state_t state_q;
  logic [7:0] tx_shift_q, rx_shift_q;
  logic [2:0] bitcnt_q;
  logic       need_load_q;

  logic [7:0] rx_hold_q, rx_hold_d, tx_hold_q, tx_hold_d, default_q, default_d;
  logic       rx_full_q, rx_full_d, tx_empty_q, tx_empty_d;
  logic       rx_ovr_q, rx_ovr_d, tx_und_q, tx_und_d;
  logic [2:0] ctrl_q, ctrl_d;

  logic busy, enable, abort, active, start_cs, byte_start, byte_done;
  logic pop, wr_data, wr_status, wr_ctrl, wr_default, irq_pend;
  logic [7:0] rx_byte, load_byte, status;

  always_comb begin
    busy       = (state_q == SHIFT);
    enable     = ctrl_q[CT_EN];
    abort      = busy & (cs_n_rise | ~enable);
    active     = busy & ~abort;
    start_cs   = ~busy & cs_n_fall & enable;
    byte_start = start_cs | (active & sclk_fall & need_load_q);
    byte_done  = active & sclk_rise & (bitcnt_q == 3'd7);
    rx_byte    = {rx_shift_q[6:0], mosi_lvl};
    load_byte  = tx_empty_q ? default_q : tx_hold_q;
    pop        = i_cs & i_rwb  & (i_addr == REG_DATA);
    wr_data    = i_cs & ~i_rwb & (i_addr == REG_DATA);
    wr_status  = i_cs & ~i_rwb & (i_addr == REG_STATUS);
    wr_ctrl    = i_cs & ~i_rwb & (i_addr == REG_CTRL);
    wr_default = i_cs & ~i_rwb & (i_addr == REG_DEFAULT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bitcnt_q    <= '0;
      need_load_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_cs) begin
            state_q     <= SHIFT;
            tx_shift_q  <= load_byte;
            bitcnt_q    <= '0;
            need_load_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            need_load_q <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_q <= rx_byte;
            if (bitcnt_q == 3'd7) begin
              bitcnt_q    <= '0;
              need_load_q <= 1'b1;
            end else begin
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end else if (sclk_fall) begin
            // bitcnt==0 with need_load set marks the first fall of the next byte
            if (bitcnt_q != 3'd0) begin
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end else if (need_load_q) begin
              tx_shift_q  <= load_byte;
              need_load_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    rx_hold_d  = rx_hold_q;
    rx_full_d  = rx_full_q;
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    rx_ovr_d   = rx_ovr_q;
    tx_und_d   = tx_und_q;
    ctrl_d     = ctrl_q;
    default_d  = default_q;

    if (pop) rx_full_d = 1'b0;
    if (wr_status) begin
      if (i_data[ST_RX_OVR]) rx_ovr_d = 1'b0;
      if (i_data[ST_TX_UND]) tx_und_d = 1'b0;
    end
    // A pop on the completing cycle frees the holding register for the new byte
    if (byte_done) begin
      if (!rx_full_d) begin
        rx_hold_d = rx_byte;
        rx_full_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
    if (byte_start) begin
      if (!tx_empty_q) tx_empty_d = 1'b1;
      else             tx_und_d   = 1'b1;
    end
    if (wr_data) begin
      tx_hold_d  = i_data;
      tx_empty_d = 1'b0;
    end
    if (wr_ctrl) begin
`ifdef SPI_TARGET_IRQ_EN
      ctrl_d = i_data[2:0];
`else
      ctrl_d = {2'b00, i_data[CT_EN]};
`endif
    end
    if (wr_default) default_d = i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_hold_q  <= '0;
      rx_full_q  <= 1'b0;
      tx_hold_q  <= '0;
      tx_empty_q <= 1'b1;
      rx_ovr_q   <= 1'b0;
      tx_und_q   <= 1'b0;
      ctrl_q     <= '0;
      default_q  <= DEFAULT_TX;
    end else begin
      rx_hold_q  <= rx_hold_d;
      rx_full_q  <= rx_full_d;
      tx_hold_q  <= tx_hold_d;
      tx_empty_q <= tx_empty_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_und_q   <= tx_und_d;
      ctrl_q     <= ctrl_d;
      default_q  <= default_d;
    end
  end

`ifdef SPI_TARGET_IRQ_EN
  logic irqb_q;
  assign irq_pend = (ctrl_q[CT_RX_IRQ] & rx_full_q) | (ctrl_q[CT_TX_IRQ] & tx_empty_q)
                  | rx_ovr_q | tx_und_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) irqb_q <= 1'b1;
    else          irqb_q <= ~irq_pend;
  end
  assign o_irqb = irqb_q;
`else
  assign irq_pend = 1'b0;
  assign o_irqb   = 1'b1;
`endif

  always_comb begin
    status              = '0;
    status[ST_RX_FULL]  = rx_full_q;
    status[ST_TX_EMPTY] = tx_empty_q;
    status[ST_RX_OVR]   = rx_ovr_q;
    status[ST_TX_UND]   = tx_und_q;
    status[ST_BUSY]     = busy;
    status[ST_IRQ]      = irq_pend;
    o_data              = '0;
    case (i_addr)
      REG_DATA:    o_data = rx_hold_q;
      REG_STATUS:  o_data = status;
      REG_CTRL:    o_data = {5'b00000, ctrl_q};
      REG_DEFAULT: o_data = default_q;
    endcase
  end

  assign o_spi_miso_oe = busy;
  assign o_spi_miso    = busy & tx_shift_q[7];

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: transaction-level model of registers and SPI bytes, per-cycle pin checks.
module tb_spi_target;
  localparam int unsigned SYNC = 2;
  localparam int H = 8;
  localparam int S = SYNC + 3;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cs = 1'b0, rwb = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
  logic       miso, miso_oe, irqb;

  spi_target #(.SYNC_STAGES(SYNC), .DEFAULT_TX(8'hFF)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs), .i_rwb(rwb), .i_addr(addr),
    .i_data(wdata), .o_data(rdata), .i_spi_cs_n(spi_cs_n), .i_spi_clk(spi_sclk),
    .i_spi_mosi(spi_mosi), .o_spi_miso(miso), .o_spi_miso_oe(miso_oe), .o_irqb(irqb)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_rx_hold, m_tx_hold, m_def, m_cur, m_rx, cap;
  logic       m_rx_full, m_tx_empty, m_ovr, m_und, m_busy, m_need;
  logic [2:0] m_ctrl;
  int         m_cnt;

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_rx_hold = 8'h00; m_tx_hold = 8'h00; m_def = 8'hFF; m_cur = 8'h00; m_rx = 8'h00;
    m_rx_full = 1'b0; m_tx_empty = 1'b1; m_ovr = 1'b0; m_und = 1'b0;
    m_busy = 1'b0; m_need = 1'b0; m_ctrl = 3'b000; m_cnt = 0;
  endfunction

  function automatic logic exp_irqb();
`ifdef SPI_TARGET_IRQ_EN
    return ~((m_ctrl[1] & m_rx_full) | (m_ctrl[2] & m_tx_empty) | m_ovr | m_und);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] exp_rd(logic [1:0] a);
    case (a)
      2'd0:    return m_rx_hold;
      2'd1:    return {~exp_irqb(), 2'b00, m_busy, m_und, m_ovr, m_tx_empty, m_rx_full};
      2'd2:    return {5'b00000, m_ctrl};
      default: return m_def;
    endcase
  endfunction

  function automatic void byte_start();
    if (!m_tx_empty) begin m_cur = m_tx_hold; m_tx_empty = 1'b1; end
    else begin m_cur = m_def; m_und = 1'b1; end
  endfunction

  function automatic void byte_done(logic [7:0] b);
    if (!m_rx_full) begin m_rx_hold = b; m_rx_full = 1'b1; end
    else m_ovr = 1'b1;
  endfunction

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("miso_oe", {7'b0, miso_oe}, {7'b0, m_busy});
      check("miso", {7'b0, miso}, {7'b0, m_busy & m_cur[7]});
      check("irqb", {7'b0, irqb}, {7'b0, exp_irqb()});
    end
  end

  task automatic hold();
    repeat (S) @(negedge clk);
    chk_en = 1'b1;
    repeat (H - S) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    bit save;
    save = chk_en;
    @(negedge clk);
    chk_en = 1'b0; cs = 1'b1; rwb = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; rwb = 1'b1;
    case (a)
      2'd0: begin m_tx_hold = d; m_tx_empty = 1'b0; end
      2'd1: begin if (d[2]) m_ovr = 1'b0; if (d[3]) m_und = 1'b0; end
      2'd2: begin
`ifdef SPI_TARGET_IRQ_EN
        m_ctrl = d[2:0];
`else
        m_ctrl = {2'b00, d[0]};
`endif
        if (!d[0]) begin m_busy = 1'b0; m_cnt = 0; m_need = 1'b0; end
      end
      default: m_def = d;
    endcase
    repeat (2) @(negedge clk);
    chk_en = save;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] v);
    bit save;
    save = chk_en;
    @(negedge clk);
    chk_en = 1'b0; cs = 1'b1; rwb = 1'b1; addr = a;
    #1;
    v = rdata;
    check($sformatf("read_reg%0d", a), v, exp_rd(a));
    @(negedge clk);
    cs = 1'b0;
    if (a == 2'd0) m_rx_full = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = save;
  endtask

  task automatic set_cs_fall(input bit wr, input logic [7:0] d);
    @(negedge clk);
    spi_cs_n = 1'b0; chk_en = 1'b0;
    if (m_ctrl[0] && !m_busy) begin
      m_busy = 1'b1; m_cnt = 0; m_need = 1'b0; byte_start();
    end
    if (wr) begin
      repeat (SYNC) @(negedge clk);
      cs = 1'b1; rwb = 1'b0; addr = 2'd0; wdata = d;
      @(negedge clk);
      cs = 1'b0; rwb = 1'b1;
      m_tx_hold = d; m_tx_empty = 1'b0;
    end
    cap = 8'h00;
    hold();
  endtask

  task automatic set_cs_rise();
    @(negedge clk);
    spi_cs_n = 1'b1; chk_en = 1'b0;
    m_busy = 1'b0; m_cnt = 0; m_need = 1'b0;
    hold();
  endtask

  task automatic sclk_rise(input logic b, input bit pop);
    bit done;
    logic [7:0] v;
    done = 1'b0;
    @(negedge clk);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    if (m_busy) cap = {cap[6:0], miso};
    spi_sclk = 1'b1; chk_en = 1'b0;
    if (m_busy) begin
      m_rx = {m_rx[6:0], b};
      if (m_cnt == 7) begin m_cnt = 0; m_need = 1'b1; done = 1'b1; end
      else m_cnt++;
    end
    if (pop) begin
      repeat (SYNC) @(negedge clk);
      cs = 1'b1; rwb = 1'b1; addr = 2'd0;
      #1;
      v = rdata;
      check("pop_at_done", v, m_rx_hold);
      m_rx_full = 1'b0;
      @(negedge clk);
      cs = 1'b0;
    end
    if (done) byte_done(m_rx);
    hold();
  endtask

  task automatic sclk_fall();
    @(negedge clk);
    spi_sclk = 1'b0; chk_en = 1'b0;
    if (m_busy) begin
      if (m_cnt != 0) m_cur = {m_cur[6:0], 1'b0};
      else if (m_need) begin byte_start(); m_need = 1'b0; end
    end
    hold();
  endtask

  // Bytes in bytes[7:0] first; the last byte ends with cs_n rising while SCLK is high.
  task automatic spi_xfer(input logic [23:0] bytes, input int n, input int pop_idx,
                          input bit wr_start, input logic [7:0] wd);
    set_cs_fall(wr_start, wd);
    for (int i = 0; i < n; i++) begin
      logic [7:0] bt;
      bt = bytes[8*i +: 8];
      for (int j = 0; j < 8; j++) begin
        sclk_rise(bt[7-j], (pop_idx == i) && (j == 7));
        if (!((i == n - 1) && (j == 7))) sclk_fall();
      end
    end
    set_cs_rise();
    sclk_fall();
  endtask

  task automatic spi_partial(input int nb, input logic [7:0] bt);
    set_cs_fall(1'b0, 8'h00);
    for (int j = 0; j < nb; j++) begin
      sclk_rise(bt[7-j], 1'b0);
      sclk_fall();
    end
    set_cs_rise();
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;

    // reset state
    check("reset_irqb", {7'b0, irqb}, 8'h01);
    check("reset_oe", {7'b0, miso_oe}, 8'h00);
    cpu_rd(2'd0, v); check("reset_data", v, 8'h00);
    cpu_rd(2'd1, v); check("reset_status", v, 8'h02);
    cpu_rd(2'd2, v); check("reset_ctrl", v, 8'h00);
    cpu_rd(2'd3, v); check("reset_default", v, 8'hFF);

    // basic exchange
    cpu_wr(2'd2, 8'h01);
    cpu_wr(2'd0, 8'hA5);
    spi_xfer(24'h00003C, 1, -1, 1'b0, 8'h00);
    check("t1_miso_byte", cap, 8'hA5);
    cpu_rd(2'd1, v); check("t1_status", v, 8'h03);
    cpu_rd(2'd0, v); check("t1_data", v, 8'h3C);
    cpu_rd(2'd1, v); check("t1_status_after", v, 8'h02);

    // underrun sends DEFAULT
    cpu_wr(2'd3, 8'h5A);
    spi_xfer(24'h000081, 1, -1, 1'b0, 8'h00);
    check("t2_miso_byte", cap, 8'h5A);
    cpu_rd(2'd1, v); check("t2_underrun", v & 8'h08, 8'h08);
    cpu_wr(2'd1, 8'h08);
    cpu_rd(2'd1, v); check("t2_underrun_clr", v & 8'h08, 8'h00);
    cpu_rd(2'd0, v); check("t2_data", v, 8'h81);

    // overrun keeps first byte
    spi_xfer(24'h002211, 2, -1, 1'b0, 8'h00);
    cpu_rd(2'd0, v); check("t3_data", v, 8'h11);
    cpu_rd(2'd1, v); check("t3_status", v & 8'h05, 8'h04);

    // cs_n abort mid-byte
    cpu_wr(2'd1, 8'h0C);
    spi_partial(4, 8'hC3);
    cpu_rd(2'd1, v); check("t4_status", v & 8'h11, 8'h00);
    spi_xfer(24'h000077, 1, -1, 1'b0, 8'h00);
    cpu_rd(2'd0, v); check("t4_data", v, 8'h77);

    // pop on the completion cycle of byte 2
    cpu_wr(2'd1, 8'h0C);
    spi_xfer(24'h0055AA, 2, 1, 1'b0, 8'h00);
    cpu_rd(2'd1, v); check("t5_status", v & 8'h05, 8'h01);
    cpu_rd(2'd0, v); check("t5_data", v, 8'h55);

    // TX load and CPU write on the same cycle
    cpu_wr(2'd0, 8'h3E);
    spi_xfer(24'h000000, 2, -1, 1'b1, 8'hC7);
    check("txload_second_byte", cap, 8'hC7);
    cpu_rd(2'd0, v);

    // enable drop mid-byte
    cpu_wr(2'd1, 8'h0C);
    set_cs_fall(1'b0, 8'h00);
    for (int j = 0; j < 3; j++) begin sclk_rise(1'b1, 1'b0); sclk_fall(); end
    cpu_wr(2'd2, 8'h00);
    set_cs_rise();
    cpu_wr(2'd2, 8'h01);
    cpu_rd(2'd1, v); check("en_abort_status", v & 8'h11, 8'h00);

    // interrupt
    cpu_wr(2'd1, 8'h0C);
    cpu_wr(2'd0, 8'h12);
`ifdef SPI_TARGET_IRQ_EN
    cpu_wr(2'd2, 8'h03);
    check("t6_irqb_idle", {7'b0, irqb}, 8'h01);
    spi_xfer(24'h00009C, 1, -1, 1'b0, 8'h00);
    check("t6_irqb_rx", {7'b0, irqb}, 8'h00);
    cpu_rd(2'd0, v);
    check("t6_irqb_popped", {7'b0, irqb}, 8'h01);
    cpu_wr(2'd2, 8'h01);
`else
    cpu_wr(2'd2, 8'h07);
    cpu_rd(2'd2, v); check("t6_ctrl_masked", v, 8'h01);
    spi_xfer(24'h00009C, 1, -1, 1'b0, 8'h00);
    check("t6_irqb_tied", {7'b0, irqb}, 8'h01);
    cpu_rd(2'd0, v);
`endif

    // reset mid-transfer
    set_cs_fall(1'b0, 8'h00);
    for (int j = 0; j < 3; j++) begin sclk_rise(1'b0, 1'b0); sclk_fall(); end
    @(negedge clk);
    chk_en = 1'b0; rst_n = 1'b0; spi_cs_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_mid_oe", {7'b0, miso_oe}, 8'h00);
    rst_n = 1'b1;
    repeat (S) @(negedge clk);
    chk_en = 1'b1;
    cpu_rd(2'd1, v); check("rst_mid_status", v, 8'h02);
    cpu_wr(2'd2, 8'h01);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      logic [7:0] d;
      int op, n;
      op = int'($urandom_range(0, 8));
      d = 8'($urandom);
      case (op)
        0: cpu_wr(2'd0, d);
        1: cpu_wr(2'd3, d);
        2: cpu_rd(2'd0, v);
        3: cpu_rd(2'($urandom_range(1, 3)), v);
        4: cpu_wr(2'd1, d & 8'h0C);
        5: begin
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
          cpu_wr(2'd2, d);
        end
        8: spi_partial(int'($urandom_range(1, 7)), d);
        default: begin
          n = int'($urandom_range(1, 3));
          spi_xfer(24'($urandom), n, int'($urandom_range(0, n)) - 1,
                   bit'($urandom_range(0, 1)), 8'($urandom));
        end
      endcase
    end
    cpu_rd(2'd1, v);
    cpu_rd(2'd0, v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
